regfile_sb: RTL and testbench

- Parametrised successor to the core's integer register file.
- Width, depth and read-port count are configurable; the register array is cleared by reset.
- Write-to-read bypass is built in, plus an optional registered read stage.
- Integrated per-register busy scoreboard: decode marks a destination pending at issue; writeback clears it.
- Sits between decode (read/issue) and writeback (write/clear) of the RISC-V pipeline.

---
 rtl/regfile_sb_if.sv | 35 +++
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bus bundle between the register file and the decode/writeback stages.
//   master : decode/writeback side, drives write, read-address and issue fields
//   slave  : register file, returns read data, per-port busy and full scoreboard
// Signals:
//   wr_en/wr_addr/wr_data : writeback write (also clears the scoreboard bit)
//   rd_addr               : packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data               : packed read data, port k = [k*DATA_W +: DATA_W]
//   rd_busy               : per-port pending-write flag
//   iss_en/iss_addr       : issue, marks the destination pending
//   busy_vec              : whole scoreboard, one bit per register
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic [(1<<ADDR_W)-1:0]   busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised integer register file with write-to-read bypass, optional
// registered read stage and a per-register busy scoreboard.
// Ports:
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset, clears array, scoreboard and
//           (when RD_REG=1) the registered read data
//   bus   : regfile_sb_if slave modport (write, read, issue, scoreboard)
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int RD_REG   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         busy_d;
  logic                     wr_act;
  logic [NUM_RD*DATA_W-1:0] rd_data_d;

  // A write to register 0 is dropped entirely when it is hard-wired to zero,
  // so it must not bypass either.
  assign wr_act = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_act) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Issue is applied after the writeback clear so a same-cycle issue to the
  // same register (a new producer) keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.wr_en)  busy_d[bus.wr_addr]  = 1'b0;
    if (bus.iss_en) busy_d[bus.iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign bus.busy_vec = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] raddr;
    logic              hit;
    logic              zero_rd;

    assign raddr   = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign hit     = wr_act && (bus.wr_addr == raddr);
    assign zero_rd = (ZERO_REG != 0) && (raddr == '0);

    assign rd_data_d[k*DATA_W +: DATA_W] = zero_rd ? '0 :
                                           hit     ? bus.wr_data : mem_q[raddr];

    // The clearing writeback is already visible this cycle, matching bypass.
    assign bus.rd_busy[k] = busy_q[raddr] & ~(bus.wr_en & (bus.wr_addr == raddr));
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [NUM_RD*DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
    end

    assign bus.rd_data = rd_data_q;
  end else begin : g_rd_comb
    assign bus.rd_data = rd_data_d;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default instance (combinational read,
// hard-wired zero register) and a wide 3-port instance with registered read
// and a writable register 0.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if0 ();
  regfile_sb_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(3)) if1 ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .RD_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  regfile_sb #(.DATA_W(64), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0), .RD_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr_en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [31:0] bv;
  } vec_t;

  vec_t tv[12];

  initial begin
    // Expected outputs are those seen in the same cycle the inputs are applied
    // (combinational read, busy_vec shows state from previous edges).
    tv[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd0, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 32'h0};
    tv[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
    tv[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
    tv[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd3, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
    tv[5]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd9, 5'd5, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'h200};
    tv[6]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd9, 5'd5, 32'h99,       32'hDEADBEEF, 1'b0, 1'b0, 32'h200};
    tv[7]  = '{1'b1, 5'd9, 32'h77,       1'b1, 5'd9, 5'd9, 5'd0, 32'h77,       32'h0,        1'b0, 1'b0, 32'h0};
    tv[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd9, 5'd7, 32'h77,       32'h0,        1'b1, 1'b0, 32'h200};
    tv[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd7, 32'h77,       32'h0,        1'b1, 1'b1, 32'h280};
    tv[10] = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 5'd9, 5'd7, 32'h77,       32'h0,        1'b1, 1'b1, 32'h280};
    tv[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd7, 32'h44,       32'h0,        1'b0, 1'b1, 32'h280};

    rst_n = 1'b0;
    if0.wr_en = 1'b0; if0.wr_addr = '0; if0.wr_data = '0;
    if0.rd_addr = '0; if0.iss_en = 1'b0; if0.iss_addr = '0;
    if1.wr_en = 1'b0; if1.wr_addr = '0; if1.wr_data = '0;
    if1.rd_addr = '0; if1.iss_en = 1'b0; if1.iss_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy_vec0", 64'(if0.busy_vec), 64'h0);
    chk("rst rd_data0",  if0.rd_data, 64'h0);
    chk("rst busy_vec1", 64'(if1.busy_vec), 64'h0);
    chk("rst rd_data1 lo", if1.rd_data[63:0], 64'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven: bypass, zero register, scoreboard set/clear/priority.
    for (int i = 0; i < 12; i++) begin
      if0.wr_en    = tv[i].wr_en;
      if0.wr_addr  = tv[i].wa;
      if0.wr_data  = tv[i].wd;
      if0.iss_en   = tv[i].iss;
      if0.iss_addr = tv[i].ia;
      if0.rd_addr  = {tv[i].ra1, tv[i].ra0};
      #1;
      chk($sformatf("v%0d rd_data0", i), 64'(if0.rd_data[31:0]),  64'(tv[i].d0));
      chk($sformatf("v%0d rd_data1", i), 64'(if0.rd_data[63:32]), 64'(tv[i].d1));
      chk($sformatf("v%0d rd_busy0", i), 64'(if0.rd_busy[0]),     64'(tv[i].b0));
      chk($sformatf("v%0d rd_busy1", i), 64'(if0.rd_busy[1]),     64'(tv[i].b1));
      chk($sformatf("v%0d busy_vec", i), 64'(if0.busy_vec),       64'(tv[i].bv));
      tick();
    end
    if0.wr_en = 1'b0; if0.iss_en = 1'b0;

    // Wide instance: register 0 writable and trackable.
    if1.wr_en = 1'b1; if1.wr_addr = 5'd0; if1.wr_data = 64'h12345678;
    if1.iss_en = 1'b1; if1.iss_addr = 5'd0;
    tick();
    if1.wr_en = 1'b0; if1.iss_en = 1'b0;
    if1.rd_addr = {5'd0, 5'd0, 5'd0};
    #1;
    chk("w r0 rd_busy", 64'(if1.rd_busy[0]), 64'h1);
    chk("w r0 busy_vec", 64'(if1.busy_vec), 64'h1);
    tick();
    chk("w r0 rd_data", if1.rd_data[63:0], 64'h12345678);

    // Registered-read bypass versus array read.
    if1.wr_en = 1'b1; if1.wr_addr = 5'd3; if1.wr_data = 64'h22;
    tick();
    if1.wr_data = 64'h11;
    if1.rd_addr = {5'd0, 5'd0, 5'd3};
    tick();
    chk("w bypass reg", if1.rd_data[63:0], 64'h11);
    if1.wr_en = 1'b0;
    tick();
    chk("w array reg", if1.rd_data[63:0], 64'h11);

    // Multi-port, including two ports on one address.
    if1.wr_en = 1'b1;
    if1.wr_addr = 5'd1;  if1.wr_data = 64'h1111_2222_3333_4444; tick();
    if1.wr_addr = 5'd2;  if1.wr_data = 64'hAAAA_BBBB_CCCC_DDDD; tick();
    if1.wr_addr = 5'd31; if1.wr_data = 64'hFEDC_BA98_7654_3210; tick();
    if1.wr_en = 1'b0;
    if1.rd_addr = {5'd31, 5'd2, 5'd1};
    tick();
    chk("mp p0 r1",  if1.rd_data[63:0],    64'h1111_2222_3333_4444);
    chk("mp p1 r2",  if1.rd_data[127:64],  64'hAAAA_BBBB_CCCC_DDDD);
    chk("mp p2 r31", if1.rd_data[191:128], 64'hFEDC_BA98_7654_3210);
    if1.rd_addr = {5'd1, 5'd31, 5'd31};
    tick();
    chk("mp p0 r31", if1.rd_data[63:0],    64'hFEDC_BA98_7654_3210);
    chk("mp p1 r31", if1.rd_data[127:64],  64'hFEDC_BA98_7654_3210);
    chk("mp p2 r1",  if1.rd_data[191:128], 64'h1111_2222_3333_4444);

    // Asynchronous reset in the middle of operation.
    if0.wr_en = 1'b1; if0.wr_addr = 5'd5; if0.wr_data = 32'h0BADF00D;
    if0.iss_en = 1'b1; if0.iss_addr = 5'd7;
    if0.rd_addr = {5'd7, 5'd5};
    tick();
    if0.wr_en = 1'b0; if0.iss_en = 1'b0;
    #1;
    chk("pre-rst r5", 64'(if0.rd_data[31:0]), 64'h0BADF00D);
    chk("pre-rst busy7", 64'(if0.busy_vec[7]), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst r5", 64'(if0.rd_data[31:0]), 64'h0);
    chk("async rst busy_vec0", 64'(if0.busy_vec), 64'h0);
    chk("async rst busy_vec1", 64'(if1.busy_vec), 64'h0);
    chk("async rst rd_data1", if1.rd_data[63:0], 64'h0);
    if0.wr_en = 1'b1; if0.wr_addr = 5'd6; if0.wr_data = 32'h66;
    tick();
    #1;
    rst_n = 1'b1;
    if0.wr_en = 1'b0;
    if0.rd_addr = {5'd5, 5'd6};
    #1;
    chk("lost write r6", 64'(if0.rd_data[31:0]), 64'h0);
    chk("post-rst r5", 64'(if0.rd_data[63:32]), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
